// File: rtl/sync_link_pkg.sv
// Definitions shared by both ends of the slow-rate sync-word link:
// frame field width, default preamble and the link-level state encoding.
package sync_link_pkg;

  localparam int FRAME_FIELD_BITS = 10;

  typedef logic [FRAME_FIELD_BITS-1:0] field_t;

  localparam field_t     SYNC_WORD_DEFAULT = 10'b1111011010;
  localparam logic [3:0] LAST_IDX          = 4'(FRAME_FIELD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } link_state_e;

endpackage

// File: rtl/bit_rate_gen.sv
// Bit-rate clock enable: counts 0..DIV_RATIO-1 while enabled and flags the
// last clk cycle of each serial bit.
module bit_rate_gen #(
  parameter int DIV_RATIO = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW       = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DIV_RATIO - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == TERMINAL) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == TERMINAL);

endmodule

// File: rtl/sync_frame_tx.sv
// Serial transmitter for the sync-word link: sends SYNC_WORD then a 10-bit
// payload, both LSB-first, each bit held for DIV_RATIO clk cycles.
module sync_frame_tx
  import sync_link_pkg::*;
#(
  parameter int     DIV_RATIO  = 10,
  parameter field_t SYNC_WORD  = SYNC_WORD_DEFAULT,
  parameter logic   IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       serial_o,
  output logic       busy_o,
  output logic       bit_tick_o,
  output logic       frame_done_o
);

  link_state_e state, next_state;
  logic [3:0]  idx, next_idx;
  field_t      payload, next_payload;
  logic        accept, in_frame, tick, last_bit, next_serial;

  assign in_frame = (state != IDLE);
  assign accept   = valid_i && (state == IDLE);
  assign last_bit = tick && (idx == LAST_IDX);

  bit_rate_gen #(
    .DIV_RATIO (DIV_RATIO)
  ) u_rate (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (in_frame),
    .tick   (tick)
  );

  // serial_o and frame_done_o are computed one step ahead so they come
  // straight out of flops and line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      payload      <= '0;
      serial_o     <= IDLE_LEVEL;
      frame_done_o <= 1'b0;
    end else begin
      state        <= next_state;
      idx          <= next_idx;
      payload      <= next_payload;
      serial_o     <= next_serial;
      frame_done_o <= (state == DATA) && last_bit;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    next_idx     = idx;
    next_payload = payload;
    case (state)
      IDLE: begin
        if (valid_i) begin
          next_state   = SYNC;
          next_idx     = '0;
          next_payload = data_i;
        end
      end
      SYNC: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            next_state = DATA;
            next_idx   = '0;
          end else begin
            next_idx = idx + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            next_state = IDLE;
            next_idx   = '0;
          end else begin
            next_idx = idx + 4'd1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_o     = (state == IDLE);
    busy_o      = in_frame;
    bit_tick_o  = tick;
    next_serial = IDLE_LEVEL;
    case (next_state)
      SYNC:    next_serial = SYNC_WORD[next_idx];
      DATA:    next_serial = next_payload[next_idx];
      default: next_serial = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Self-checking bench for sync_frame_tx: table-driven frames, scoreboard of
// expected serial sequences, multi-cycle corner cases and sync-word loopback.
module tb_sync_frame_tx;

  localparam int         DIV  = 10;
  localparam int         DIV2 = 2;
  localparam logic [9:0] SW   = 10'b1111011010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i, valid2;
  logic [9:0] data_i, data2;
  logic       ready_o, serial_o, busy_o, bit_tick_o, frame_done_o;
  logic       ready2, serial2, busy2, tick2, done2;

  always #5 clk = ~clk;

  sync_frame_tx #(.DIV_RATIO(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .serial_o     (serial_o),
    .busy_o       (busy_o),
    .bit_tick_o   (bit_tick_o),
    .frame_done_o (frame_done_o)
  );

  sync_frame_tx #(.DIV_RATIO(DIV2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data2),
    .valid_i      (valid2),
    .ready_o      (ready2),
    .serial_o     (serial2),
    .busy_o       (busy2),
    .bit_tick_o   (tick2),
    .frame_done_o (done2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [9:0]  data;
    logic [19:0] bits;   // expected serial_o sequence, bit 0 sent first
  } vec_t;

  logic [19:0] sb_q[$];

  // Frame monitor for the DIV=10 instance: bit length, stability, content.
  int          nbits, cyc;
  logic        first_val, unstable;
  logic [19:0] cap;
  initial begin
    nbits = 0; cyc = 0; unstable = 1'b0; first_val = 1'b0; cap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nbits = 0; cyc = 0; unstable = 1'b0;
      end else begin
        if (busy_o) begin
          cyc++;
          if (cyc == 1) first_val = serial_o;
          else if (serial_o !== first_val) unstable = 1'b1;
        end
        if (bit_tick_o) begin
          check("bit_len", cyc, DIV);
          check("bit_stable", {31'd0, unstable}, 0);
          if (nbits < 20) cap[nbits] = serial_o;
          nbits++;
          cyc = 0;
          unstable = 1'b0;
        end
        if (frame_done_o) begin
          check("bits_per_frame", nbits, 20);
          check("sb_nonempty", {31'd0, sb_q.size() != 0}, 1);
          if (sb_q.size() != 0) check("frame_bits", {12'd0, cap}, {12'd0, sb_q.pop_front()});
          nbits = 0;
        end
      end
    end
  end

  // Receiver-side sync detectors fed from each serial line.
  logic [9:0] win1, win2, pay2, exp2;
  int         match1 = 0, match2 = 0, tc1, tc2;
  logic       loop_en = 1'b0;
  initial begin
    win1 = '0; win2 = '0; tc1 = 0; tc2 = 0; pay2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        win1 = '0; win2 = '0; tc1 = 0; tc2 = 0;
      end else begin
        if (bit_tick_o) begin
          tc1++;
          win1 = {serial_o, win1[9:1]};
          if (loop_en && win1 == SW) begin
            match1++;
            check("match1_pos", tc1, 10);
          end
        end
        if (frame_done_o) tc1 = 0;
        if (tick2) begin
          tc2++;
          win2 = {serial2, win2[9:1]};
          if (tc2 > 10) pay2[tc2-11] = serial2;
          if (win2 == SW) begin
            match2++;
            check("match2_pos", tc2, 10);
          end
        end
        if (done2) begin
          check("ticks_per_frame2", tc2, 20);
          check("payload2", {22'd0, pay2}, {22'd0, exp2});
          tc2 = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ready_reached", {31'd0, ready_o}, 1);
  endtask

  // Drive one accept; returns on the first negedge after the accept edge.
  task automatic send1(input logic [9:0] d, input logic [19:0] exp_bits);
    valid_i = 1'b1;
    data_i  = d;
    sb_q.push_back(exp_bits);
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = ~d;
  endtask

  // Counts cycles after accept (starting at 1) until frame_done_o.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!frame_done_o && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'd0, frame_done_o}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[4];
  int   lat, n, rdy_hi, dn, m0;

  initial begin
    vecs[0] = '{10'h2A5, {10'h2A5, 10'b1111011010}};
    vecs[1] = '{10'h155, {10'h155, 10'b1111011010}};
    vecs[2] = '{10'h0F0, {10'h0F0, 10'b1111011010}};
    vecs[3] = '{10'h3C1, {10'h3C1, 10'b1111011010}};

    valid_i = 1'b0; data_i = '0; valid2 = 1'b0; data2 = '0; exp2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready_o}, 1);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_serial", {31'd0, serial_o}, 0);
    check("rst_tick", {31'd0, bit_tick_o}, 0);
    check("rst_done", {31'd0, frame_done_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single frames.
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      send1(vecs[i].data, vecs[i].bits);
      check("busy_after_accept", {31'd0, busy_o}, 1);
      wait_done(lat);
      check("latency", lat, 201);
      check("ready_at_done", {31'd0, ready_o}, 1);
      check("idle_at_done", {31'd0, serial_o}, 0);
    end

    // Back-to-back with valid_i held high.
    wait_ready();
    valid_i = 1'b1;
    data_i  = 10'h3FF;
    sb_q.push_back({10'h3FF, SW});
    @(negedge clk);
    data_i = 10'h000;
    wait_done(lat);
    check("b2b_lat1", lat, 201);
    check("b2b_ready", {31'd0, ready_o}, 1);
    check("b2b_gap_idle", {31'd0, serial_o}, 0);
    sb_q.push_back({10'h000, SW});
    @(negedge clk);
    check("b2b_restart", {31'd0, busy_o}, 1);
    valid_i = 1'b0;
    wait_done(lat);
    check("b2b_lat2", lat, 201);

    // valid_i while busy is ignored.
    wait_ready();
    send1(10'h0F0, {10'h0F0, SW});
    repeat (30) @(negedge clk);
    valid_i = 1'b1;
    data_i  = 10'h155;
    check("ignore_ready_low", {31'd0, ready_o}, 0);
    @(negedge clk);
    valid_i = 1'b0;
    n = 32;
    rdy_hi = 0;
    while (!frame_done_o && n < 400) begin
      if (ready_o) rdy_hi++;
      @(negedge clk);
      n++;
    end
    check("ignore_lat", n, 201);
    check("ignore_ready_hi_cycles", rdy_hi, 0);
    check("sb_empty", sb_q.size(), 0);

    // Reset during DATA bit 4 (cycles 141..150 after accept).
    wait_ready();
    send1(10'h1C3, {10'h1C3, SW});
    repeat (144) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy_o}, 1);
    rst_n = 1'b0;
    #1;
    check("abort_serial", {31'd0, serial_o}, 0);
    check("abort_ready", {31'd0, ready_o}, 1);
    check("abort_busy", {31'd0, busy_o}, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (250) begin
      @(negedge clk);
      if (frame_done_o) dn++;
    end
    check("abort_no_done", dn, 0);

    // Loopback at DIV=10; first frame also proves recovery after abort.
    loop_en = 1'b1;
    m0 = match1;
    wait_ready();
    send1(10'h000, {10'h000, SW});
    wait_done(lat);
    check("post_rst_lat", lat, 201);
    wait_ready();
    send1(10'h3FF, {10'h3FF, SW});
    wait_done(lat);
    @(negedge clk);
    check("loop1_matches", match1 - m0, 2);
    loop_en = 1'b0;

    // Loopback at DIV=2.
    m0 = match2;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!ready2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      valid2 = 1'b1;
      data2  = (i == 0) ? 10'h3FF : 10'h000;
      exp2   = data2;
      @(negedge clk);
      valid2 = 1'b0;
      data2  = 10'h2AA;
      lat = 1;
      while (!done2 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("div2_lat", lat, 41);
    end
    @(negedge clk);
    check("loop2_matches", match2 - m0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
Serial transmitter for the slow-rate sync-word link. It accepts a 10-bit payload over a valid/ready handshake and emits one frame on a single wire: the 10-bit sync word, then the 10-bit payload. Both fields are sent LSB-first, and each bit is held for DIV_RATIO clk cycles. It is the transmit end for the shift-register sync detector, so the detector sees the sync word assembled in its 10-bit window.

Parameters:
DIV_RATIO, 10, clk cycles per serial bit; legal range 2..1023
SYNC_WORD, 10'b1111011010, preamble pattern; bit 0 is sent first
IDLE_LEVEL, 1'b0, serial_o level when no frame is in flight

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_i  in  10  payload; sampled only on an accept cycle
valid_i  in  1  payload request
ready_o  out  1  high while able to accept a payload (IDLE state only)
serial_o  out  1  serial line, registered
busy_o  out  1  high while a frame is in flight (SYNC or DATA)
bit_tick_o  out  1  one-cycle pulse on the last clk cycle of each serial bit
frame_done_o  out  1  one-cycle pulse on the first cycle after the final payload bit

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, serial_o=IDLE_LEVEL, ready_o=1
  - busy_o=0, bit_tick_o=0, frame_done_o=0
  - divider, bit index and shift register cleared
- All outputs are registered; no combinational path from inputs to outputs.
- Accept: a rising clk edge with valid_i && ready_o. At that edge:
  - data_i is latched
  - divider and bit index are cleared
  - state moves to SYNC
- Later changes on data_i have no effect. valid_i is ignored while ready_o=0; there is no queueing.
- States:
  - IDLE: serial_o=IDLE_LEVEL.
  - SYNC: serial_o=SYNC_WORD[idx], idx 0..9.
  - DATA: serial_o=payload[idx], idx 0..9.
- Bit timing:
  - Divider counts 0..DIV_RATIO-1 in SYNC/DATA; bit_tick_o=1 when divider==DIV_RATIO-1.
  - On a tick, idx increments and the divider wraps to 0.
  - Tick with SYNC idx 9 -> DATA with idx 0.
  - Tick with DATA idx 9 -> IDLE.
- Latency:
  - First sync bit appears on serial_o the cycle after accept.
  - Frame occupies exactly 20*DIV_RATIO cycles.
  - On return to IDLE: frame_done_o=1 and ready_o=1 in the same cycle.
- Back-to-back: accept in the frame_done_o cycle is legal. The next frame's bit 0 starts the following cycle, giving exactly one IDLE_LEVEL cycle between frames.
- busy_o = (state != IDLE). ready_o = (state == IDLE). They are always complementary.
- Reset mid-frame aborts immediately: serial_o returns to IDLE_LEVEL and the payload is discarded. No frame_done_o is issued.
- Divider width = clog2(DIV_RATIO); idx width = 4. No counter ever exceeds its terminal value.

Decomposition:
- Package sync_link_pkg:
  - SYNC_WORD_DEFAULT
  - FRAME_FIELD_BITS=10
  - state enum {IDLE, SYNC, DATA}
  - shared with the receiver side
- Sub-module bit_rate_gen (parameter DIV_RATIO):
  - inputs clk, rst_n, clear, enable
  - output tick
  - reusable by the receiver for its bit-rate clock enable

Test Plan:
- Single frame: DIV_RATIO=10, data_i=10'h2A5, valid_i for 1 cycle -> serial_o is 0,1,0,1,1,0,1,1,1,1 (sync), then 1,0,1,0,0,1,0,1,0,1. Each bit lasts 10 cycles; frame_done_o pulses at cycle 201 after accept.
- Back-to-back: valid_i held high with 10'h3FF then 10'h000 -> second accept occurs in the frame_done_o cycle, exactly one IDLE_LEVEL cycle between frames, and both payloads are correct.
- Busy ignore: pulse valid_i with 10'h155 during SYNC of a 10'h0F0 frame -> only 10'h0F0 is sent; ready_o=0 throughout the frame.
- Data stability: change data_i on the cycle after accept -> transmitted payload equals the value sampled on the accept cycle.
- Reset mid-frame: assert rst_n=0 at DATA bit 4 -> serial_o=0, ready_o=1, busy_o=0 immediately; no frame_done_o; the next accepted frame is complete and correct.
- Loopback: drive the receiver detector from serial_o with DIV_RATIO=2 and DIV_RATIO=10 -> detector match asserts once per frame after the 10th sync bit; bit_tick_o count per frame is 20.
